// File: rtl/cart_bus_responder.sv
// cart_bus_responder: cartridge-side responder for the header cartridge port.
// Header address and window selects are synchronised, then debounced over
// SETTLE_CYCLES. A byte is fetched from the cartridge ROM over a req/ack port
// and driven back on the header data lines.
// Optional feature: define CART_HIT_COUNT_EN to add the hit_count output, which
// counts acknowledged ROM reads.
module cart_bus_responder #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned ACK_TIMEOUT   = 15,
    parameter logic [7:0]  IDLE_DATA     = 8'hFF
) (
    input  logic        clk,
    input  logic        rst_L,
    input  logic [13:0] cart_addr,
    input  logic        cart_s4_L,
    input  logic        cart_s5_L,
    output logic [7:0]  cart_data,
    output logic        cart_data_oe,
    output logic [14:0] rom_addr,
    output logic        rom_req,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    output logic        busy,
    output logic        err_timeout
`ifdef CART_HIT_COUNT_EN
    ,
    output logic [15:0] hit_count
`endif
);

    // Key layout: {s4_L, s5_L, addr[13:0]}; both selects idle-high out of reset.
    localparam logic [15:0] SYNC_RST = {1'b1, 1'b1, 14'd0};
    localparam logic [8:0]  SETTLE_N = 9'(SETTLE_CYCLES);
    localparam logic [7:0]  TO_LAST  = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_FETCH,
        ST_DRIVE
    } state_e;

    logic [SYNC_STAGES-1:0][15:0] sync_q;
    logic [15:0]                  key;
    logic                         sel_valid;
    logic                         key_match;
    logic                         settle_done;

    state_e      state_q;
    logic [15:0] key_q;
    logic [7:0]  settle_cnt_q;
    logic [7:0]  wait_cnt_q;
    logic [7:0]  cart_data_q;
    logic        cart_data_oe_q;
    logic [14:0] rom_addr_q;
    logic        rom_req_q;
    logic        busy_q;
    logic        err_timeout_q;

    // Shift the raw header pins through the synchroniser chain.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            sync_q <= {SYNC_STAGES{SYNC_RST}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {cart_s4_L, cart_s5_L, cart_addr}};
        end
    end

    assign key         = sync_q[SYNC_STAGES-1];
    // Exactly one window select low; both low is a bus conflict and reads as deselect.
    assign sel_valid   = key[15] ^ key[14];
    assign key_match   = (key == key_q);
    assign settle_done = ({1'b0, settle_cnt_q} + 9'd1) >= SETTLE_N;

    // Main access sequencer: debounce the key, fetch the byte, drive it while the key holds.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state_q        <= ST_IDLE;
            key_q          <= SYNC_RST;
            settle_cnt_q   <= '0;
            wait_cnt_q     <= '0;
            cart_data_q    <= IDLE_DATA;
            cart_data_oe_q <= 1'b0;
            rom_addr_q     <= '0;
            rom_req_q      <= 1'b0;
            busy_q         <= 1'b0;
            err_timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cart_data_oe_q <= 1'b0;
                    cart_data_q    <= IDLE_DATA;
                    if (sel_valid) begin
                        key_q        <= key;
                        settle_cnt_q <= 8'd1;
                        busy_q       <= 1'b1;
                        state_q      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (!sel_valid) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else if (!key_match) begin
                        key_q        <= key;
                        settle_cnt_q <= 8'd1;
                    end else if (settle_done) begin
                        // Window bit: 0 selects S4, 1 selects S5 (s5_L low).
                        rom_addr_q <= {~key_q[14], key_q[13:0]};
                        rom_req_q  <= 1'b1;
                        wait_cnt_q <= '0;
                        state_q    <= ST_FETCH;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 8'd1;
                    end
                end
                ST_FETCH: begin
                    // Key changes here do not abort the fetch; the output enable is
                    // gated by the current key so a stale byte is never driven.
                    if (rom_ack) begin
                        cart_data_q    <= rom_data;
                        cart_data_oe_q <= key_match;
                        rom_req_q      <= 1'b0;
                        busy_q         <= 1'b0;
                        state_q        <= ST_DRIVE;
                    end else if (wait_cnt_q == TO_LAST) begin
                        err_timeout_q  <= 1'b1;
                        cart_data_q    <= IDLE_DATA;
                        cart_data_oe_q <= key_match;
                        rom_req_q      <= 1'b0;
                        busy_q         <= 1'b0;
                        state_q        <= ST_DRIVE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                ST_DRIVE: begin
                    if (key_match) begin
                        cart_data_oe_q <= 1'b1;
                    end else begin
                        cart_data_oe_q <= 1'b0;
                        cart_data_q    <= IDLE_DATA;
                        if (sel_valid) begin
                            key_q        <= key;
                            settle_cnt_q <= 8'd1;
                            busy_q       <= 1'b1;
                            state_q      <= ST_SETTLE;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CART_HIT_COUNT_EN
    logic [15:0] hit_count_q;

    // Count acknowledged fetches; timeouts leave the count alone, wraps at 16 bits.
    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            hit_count_q <= '0;
        end else if (state_q == ST_FETCH && rom_ack) begin
            hit_count_q <= hit_count_q + 16'd1;
        end
    end

    assign hit_count = hit_count_q;
`endif

    assign cart_data    = cart_data_q;
    assign cart_data_oe = cart_data_oe_q;
    assign rom_addr     = rom_addr_q;
    assign rom_req      = rom_req_q;
    assign busy         = busy_q;
    assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_cart_bus_responder.sv
// Testbench for cart_bus_responder: directed header scenarios followed by
// randomized accesses, checked against timing derived from the pin-to-output
// latency rule and a ROM-content scoreboard.
`timescale 1ns/1ps
module tb_cart_bus_responder;

    localparam int ACK_TO = 15;

    logic        clk = 1'b0;
    logic        rst_L;
    logic [13:0] cart_addr;
    logic        cart_s4_L;
    logic        cart_s5_L;
    logic [7:0]  cart_data;
    logic        cart_data_oe;
    logic [14:0] rom_addr;
    logic        rom_req;
    logic        rom_ack;
    logic [7:0]  rom_data;
    logic        busy;
    logic        err_timeout;
`ifdef CART_HIT_COUNT_EN
    logic [15:0] hit_count;
`endif

    cart_bus_responder dut (
        .clk          (clk),
        .rst_L        (rst_L),
        .cart_addr    (cart_addr),
        .cart_s4_L    (cart_s4_L),
        .cart_s5_L    (cart_s5_L),
        .cart_data    (cart_data),
        .cart_data_oe (cart_data_oe),
        .rom_addr     (rom_addr),
        .rom_req      (rom_req),
        .rom_ack      (rom_ack),
        .rom_data     (rom_data),
        .busy         (busy),
        .err_timeout  (err_timeout)
`ifdef CART_HIT_COUNT_EN
        ,
        .hit_count    (hit_count)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0] rom [0:32767];
    int         n_chk = 0;
    int         n_bad = 0;
    logic       exp_err;
    int         exp_hits;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_oe"},   32'(cart_data_oe), 32'd0);
        check_eq({tag, "_data"}, 32'(cart_data),    32'hFF);
        check_eq({tag, "_req"},  32'(rom_req),      32'd0);
        check_eq({tag, "_busy"}, 32'(busy),         32'd0);
    endtask

    // Drive a new stable key right after an edge E0; rom_req must rise at E0+4,
    // oe at E0+5+d (d = ack delay), or the timeout fires at E0+19.
    task automatic access(input logic win, input logic [13:0] addr, input int d,
                          input logic pre_oe, input logic pre_busy, output logic [7:0] dat);
        logic [14:0] ra;
        ra        = {win, addr};
        cart_addr = addr;
        cart_s4_L = win;
        cart_s5_L = ~win;
        step();
        step();
        check_eq("pre_oe",   32'(cart_data_oe), 32'(pre_oe));
        check_eq("pre_busy", 32'(busy),         32'(pre_busy));
        step();
        check_eq("settle_oe",   32'(cart_data_oe), 32'd0);
        check_eq("settle_busy", 32'(busy),         32'd1);
        check_eq("settle_req",  32'(rom_req),      32'd0);
        step();
        check_eq("fetch_req",  32'(rom_req),  32'd1);
        check_eq("fetch_addr", 32'(rom_addr), 32'(ra));
        if (d < ACK_TO) begin
            for (int k = 0; k < d; k++) begin
                step();
                check_eq("wait_oe",  32'(cart_data_oe), 32'd0);
                check_eq("wait_req", 32'(rom_req),      32'd1);
            end
            rom_ack  = 1'b1;
            rom_data = rom[ra];
            step();
            rom_ack  = 1'b0;
            rom_data = 8'($urandom);
            dat      = rom[ra];
            exp_hits++;
        end else begin
            for (int k = 0; k < ACK_TO - 1; k++) begin
                step();
                check_eq("to_wait_oe",  32'(cart_data_oe), 32'd0);
                check_eq("to_wait_req", 32'(rom_req),      32'd1);
            end
            step();
            dat     = 8'hFF;
            exp_err = 1'b1;
        end
        check_eq("drive_oe",   32'(cart_data_oe), 32'd1);
        check_eq("drive_data", 32'(cart_data),    32'(dat));
        check_eq("drive_req",  32'(rom_req),      32'd0);
        check_eq("drive_busy", 32'(busy),         32'd0);
        check_eq("drive_err",  32'(err_timeout),  32'(exp_err));
    endtask

    // Release both selects from DRIVE; oe must fall on the third edge.
    task automatic deselect();
        cart_s4_L = 1'b1;
        cart_s5_L = 1'b1;
        step();
        step();
        check_eq("desel_hold_oe", 32'(cart_data_oe), 32'd1);
        step();
        check_quiet("desel");
        step();
    endtask

    task automatic stray_ack(input logic [7:0] dat);
        rom_ack  = 1'b1;
        rom_data = ~dat;
        step();
        rom_ack  = 1'b0;
        check_eq("stray_data", 32'(cart_data),    32'(dat));
        check_eq("stray_oe",   32'(cart_data_oe), 32'd1);
        check_eq("stray_req",  32'(rom_req),      32'd0);
    endtask

    initial begin
        logic [7:0]  dat;
        logic        win;
        logic [13:0] addr;
        logic [14:0] last_key;
        logic        in_drive;
        int          d;

        rst_L     = 1'b1;
        cart_addr = '0;
        cart_s4_L = 1'b1;
        cart_s5_L = 1'b1;
        rom_ack   = 1'b0;
        rom_data  = '0;
        exp_err   = 1'b0;
        exp_hits  = 0;
        for (int i = 0; i < 32768; i++) rom[i] = 8'($urandom);
        rom[15'h0123] = 8'hA5;
        rom[15'h7FFF] = 8'h5A;

        // Reset with selects high
        #2 rst_L = 1'b0;
        step();
        step();
        check_quiet("rst");
        check_eq("rst_err",  32'(err_timeout), 32'd0);
        check_eq("rst_addr", 32'(rom_addr),    32'd0);
        rst_L = 1'b1;
        step();
        step();
        step();
        check_quiet("post_rst");

        // S4 read of 0x0123, ack after 3 cycles
        access(1'b0, 14'h0123, 3, 1'b0, 1'b0, dat);
        check_eq("t2_addr", 32'(rom_addr),  32'h0123);
        check_eq("t2_data", 32'(cart_data), 32'hA5);
        deselect();

        // S5 read of 0xBFFF
        access(1'b1, 14'h3FFF, 5, 1'b0, 1'b0, dat);
        check_eq("t3_addr", 32'(rom_addr),  32'h7FFF);
        check_eq("t3_data", 32'(cart_data), 32'h5A);
        deselect();

        // Address toggling every cycle keeps the block settling without a fetch
        cart_s4_L = 1'b0;
        cart_s5_L = 1'b1;
        for (int i = 0; i < 11; i++) begin
            cart_addr = (i % 2 == 1) ? 14'h0011 : 14'h0010;
            step();
            check_eq("tog_req", 32'(rom_req),      32'd0);
            check_eq("tog_oe",  32'(cart_data_oe), 32'd0);
            if (i >= 3) check_eq("tog_busy", 32'(busy), 32'd1);
        end
        access(1'b0, 14'h0011, 2, 1'b0, 1'b1, dat);
        deselect();

        // Both selects low is a conflict: no fetch
        cart_addr = 14'(($urandom));
        cart_s4_L = 1'b0;
        cart_s5_L = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_quiet("conflict");
        end
        cart_s4_L = 1'b1;
        cart_s5_L = 1'b1;
        step();
        step();
        step();

        // No ack: timeout, then the error flag stays set across a good read
        access(1'b0, 14'(($urandom)), ACK_TO, 1'b0, 1'b0, dat);
        deselect();
        access(1'b1, 14'(($urandom)), 4, 1'b0, 1'b0, dat);
        deselect();

        // Reset during a fetch, then a late ack after release
        cart_addr = 14'h0222;
        cart_s4_L = 1'b0;
        cart_s5_L = 1'b1;
        for (int i = 0; i < 4; i++) step();
        check_eq("rf_req", 32'(rom_req), 32'd1);
        step();
        rst_L = 1'b0;
        #1;
        check_quiet("rf_rst");
        check_eq("rf_err",  32'(err_timeout), 32'd0);
        check_eq("rf_addr", 32'(rom_addr),    32'd0);
        exp_err   = 1'b0;
        exp_hits  = 0;
        cart_s4_L = 1'b1;
        cart_s5_L = 1'b1;
        step();
        rst_L    = 1'b1;
        rom_ack  = 1'b1;
        rom_data = 8'h3C;
        step();
        rom_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_quiet("rf_late");
            step();
        end
`ifdef CART_HIT_COUNT_EN
        check_eq("rf_hits", 32'(hit_count), 32'd0);
`endif

        // Three acked reads and one timeout, chained through key changes
        access(1'b0, 14'h0100, 1, 1'b0, 1'b0, dat);
        access(1'b0, 14'h0101, 0, 1'b1, 1'b0, dat);
        access(1'b1, 14'h0101, ACK_TO, 1'b1, 1'b0, dat);
        access(1'b1, 14'h2000, 6, 1'b1, 1'b0, dat);
`ifdef CART_HIT_COUNT_EN
        check_eq("hits3", 32'(hit_count), 32'd3);
`endif
        deselect();

        // Randomized accesses
        in_drive = 1'b0;
        last_key = '0;
        for (int it = 0; it < 24; it++) begin
            win  = 1'($urandom);
            addr = 14'($urandom);
            d    = int'($urandom_range(0, 17));
            if (in_drive && {win, addr} == last_key) addr = addr ^ 14'd1;
            access(win, addr, d, in_drive, 1'b0, dat);
            in_drive = 1'b1;
            last_key = {win, addr};
            if (d < ACK_TO && $urandom_range(0, 2) == 0) stray_ack(dat);
            if ($urandom_range(0, 1) == 1) begin
                deselect();
                in_drive = 1'b0;
            end
        end
        if (in_drive) deselect();
        check_eq("final_err", 32'(err_timeout), 32'(exp_err));
`ifdef CART_HIT_COUNT_EN
        check_eq("final_hits", 32'(hit_count), 32'(exp_hits & 16'hFFFF));
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
